// File: rtl/sprite_pkg.sv
// Shared types for the sprite descriptor path: the packed descriptor record
// and the serial byte index used by the record assembler.
package sprite_pkg;

   typedef struct packed {
      logic [7:0]  id;
      logic [15:0] x;
      logic [15:0] y;
      logic [7:0]  scale;
   } sprite_t;

   localparam int unsigned SPRITE_RECORD_BYTES = 6;

   typedef enum logic [2:0] {
      IDX_ID    = 3'd0,
      IDX_X_HI  = 3'd1,
      IDX_X_LO  = 3'd2,
      IDX_Y_HI  = 3'd3,
      IDX_Y_LO  = 3'd4,
      IDX_SCALE = 3'd5
   } byte_idx_t;

endpackage

// File: rtl/sprite_record_assembler.sv
// Packs a framed byte stream into sprite descriptors. The final byte is passed
// straight through so the record is complete in the cycle of its commit pulse.
module sprite_record_assembler
   import sprite_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       frame_en,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output sprite_t    record,
   output logic       commit,
   output logic       frame_abort_partial
);

   byte_idx_t   idx;
   logic [7:0]  id;
   logic [15:0] x;
   logic [15:0] y;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         idx <= IDX_ID;
      end else if (!frame_en) begin
         idx <= IDX_ID;
      end else if (byte_valid) begin
         case (idx)
            IDX_ID: begin
               id  <= byte_data;
               idx <= IDX_X_HI;
            end
            IDX_X_HI: begin
               x[15:8] <= byte_data;
               idx     <= IDX_X_LO;
            end
            IDX_X_LO: begin
               x[7:0] <= byte_data;
               idx    <= IDX_Y_HI;
            end
            IDX_Y_HI: begin
               y[15:8] <= byte_data;
               idx     <= IDX_Y_LO;
            end
            IDX_Y_LO: begin
               y[7:0] <= byte_data;
               idx    <= IDX_SCALE;
            end
            default: idx <= IDX_ID;
         endcase
      end
   end

   assign commit              = frame_en && byte_valid && (idx == IDX_SCALE);
   assign frame_abort_partial = !frame_en && (idx != IDX_ID);
   assign record              = {id, x, y, byte_data};

endmodule

// File: rtl/sprite_desc_fifo.sv
// Circular descriptor FIFO between the SPI byte receiver and the renderer,
// with head recirculation to the tail for repeated drawing.
module sprite_desc_fifo
   import sprite_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             frame_en,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   input  logic             out_ready,
   input  logic             out_recirculate,
   output logic             out_valid,
   output logic [7:0]       sprite_id,
   output logic [15:0]      sprite_x,
   output logic [15:0]      sprite_y,
   output logic [7:0]       sprite_scale,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             frame_error
);

   localparam int PTR_W = $clog2(DEPTH);

   sprite_t            mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   sprite_t            record;
   sprite_t            head;
   logic               commit;
   logic               abort;
   logic               pop;
   logic               recirc;
   logic               plain_pop;
   logic               commit_ok;
   logic               drop;
   logic [PTR_W-1:0]   rec_ptr;

   sprite_record_assembler u_asm (
      .clock               (clock),
      .reset               (reset),
      .clear               (clear),
      .frame_en            (frame_en),
      .byte_valid          (byte_valid),
      .byte_data           (byte_data),
      .record              (record),
      .commit              (commit),
      .frame_abort_partial (abort)
   );

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign out_valid = !empty;
   assign head      = mem[rd_ptr];

   // Full-check uses the pre-edge count, so a same-cycle pop never makes room.
   always_comb begin
      pop       = out_valid && out_ready;
      recirc    = pop && out_recirculate;
      plain_pop = pop && !out_recirculate;
      commit_ok = commit && !full;
      drop      = commit && full;
      rec_ptr   = wr_ptr + PTR_W'(recirc);
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         overflow    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         if (recirc) begin
            mem[wr_ptr] <= head;
         end
         if (commit_ok) begin
            mem[rec_ptr] <= record;
         end
         rd_ptr      <= rd_ptr + PTR_W'(pop);
         wr_ptr      <= wr_ptr + PTR_W'(recirc) + PTR_W'(commit_ok);
         count       <= count + CNT_W'(commit_ok) - CNT_W'(plain_pop);
         overflow    <= overflow | drop;
         frame_error <= frame_error | abort;
      end
   end

   always_comb begin
      sprite_id    = 8'd0;
      sprite_x     = 16'd0;
      sprite_y     = 16'd0;
      sprite_scale = 8'd0;
      if (!empty) begin
         sprite_id    = head.id;
         sprite_x     = head.x;
         sprite_y     = head.y;
         sprite_scale = head.scale;
      end
   end

endmodule
